// File: rtl/seven_segment_reader.sv
// Display monitor: samples an active-low multiplexed seven-segment bus, decodes settled digits
// and hands complete frames off with valid/ack. Option macro: SEVEN_SEG_READER_SYNC_EN.
module seven_segment_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  A,
    input  logic                  B,
    input  logic                  C,
    input  logic                  D,
    input  logic                  E,
    input  logic                  F,
    input  logic                  G,
    input  logic [DIGITS-1:0]     digitSelect,
    input  logic                  frameAck,
    output logic [4*DIGITS-1:0]   digitValue,
    output logic [DIGITS-1:0]     digitValid,
    output logic [4*DIGITS-1:0]   frameValue,
    output logic                  frameValid,
    output logic                  overrun,
    output logic                  patternError
);
    // state  | meaning
    // WAIT   | digitSelect not exactly one low bit; nothing captured
    // SETTLE | one digit strobed; counting identical consecutive samples
    // HOLD   | digit captured; no recapture until the sample changes
    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam int         SW         = 7 + DIGITS;
    localparam logic [7:0] COUNT_LAST = 8'(STABLE_CYCLES);

    logic [SW-1:0] raw_bus;
    logic [SW-1:0] cur_bus;
    logic [SW-1:0] prev_bus;

    assign raw_bus = {A, B, C, D, E, F, G, digitSelect};

`ifdef SEVEN_SEG_READER_SYNC_EN
    logic [SW-1:0] sync_1;
    logic [SW-1:0] sync_2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1 <= '1;
            sync_2 <= '1;
        end else begin
            sync_1 <= raw_bus;
            sync_2 <= sync_1;
        end
    end

    assign cur_bus = sync_2;
`else
    assign cur_bus = raw_bus;
`endif

    // Bit 4 flags an undecodable pattern; bits 3:0 carry the code.
    function automatic logic [4:0] decode(input logic [6:0] lit);
        case (lit)
            7'b1111110: decode = 5'h00;
            7'b0110000: decode = 5'h01;
            7'b1101101: decode = 5'h02;
            7'b1111001: decode = 5'h03;
            7'b0110011: decode = 5'h04;
            7'b1011011: decode = 5'h05;
            7'b1011111: decode = 5'h06;
            7'b1110000: decode = 5'h07;
            7'b1111111: decode = 5'h08;
            7'b1111011: decode = 5'h09;
            7'b0000000: decode = 5'h0F;
            default:    decode = 5'h1E;
        endcase
    endfunction

    logic [1:0]          state;
    logic [1:0]          state_nx;
    logic [7:0]          count;
    logic [7:0]          count_nx;
    logic [DIGITS-1:0]   sel_lit;
    logic                one_hot;
    logic                same;
    logic                capture;
    logic                complete;
    logic [4:0]          dec;
    logic [4*DIGITS-1:0] digit_nx;
    logic [DIGITS-1:0]   valid_acc;

    assign sel_lit = ~cur_bus[DIGITS-1:0];
    assign one_hot = (sel_lit != '0) && ((sel_lit & (sel_lit - DIGITS'(1))) == '0);
    assign same    = (cur_bus == prev_bus);
    assign dec     = decode(~cur_bus[SW-1:DIGITS]);

    always_comb begin
        state_nx = state;
        count_nx = count;
        capture  = 1'b0;
        case (state)
            ST_WAIT: begin
                if (one_hot) begin
                    state_nx = ST_SETTLE;
                    count_nx = 8'd1;
                end
            end
            ST_SETTLE: begin
                if (!one_hot) begin
                    state_nx = ST_WAIT;
                    count_nx = 8'd0;
                end else if (same) begin
                    count_nx = count + 8'd1;
                    if (count + 8'd1 == COUNT_LAST) begin
                        capture  = 1'b1;
                        state_nx = ST_HOLD;
                    end
                end else begin
                    count_nx = 8'd1;
                end
            end
            ST_HOLD: begin
                if (!one_hot) begin
                    state_nx = ST_WAIT;
                    count_nx = 8'd0;
                end else if (!same) begin
                    state_nx = ST_SETTLE;
                    count_nx = 8'd1;
                end
            end
            default: begin
                state_nx = ST_WAIT;
                count_nx = 8'd0;
            end
        endcase
    end

    always_comb begin
        digit_nx = digitValue;
        for (int i = 0; i < DIGITS; i++) begin
            if (capture && sel_lit[i]) begin
                digit_nx[4*i +: 4] = dec[3:0];
            end
        end
    end

    assign valid_acc = digitValid | (capture ? sel_lit : '0);
    assign complete  = capture && (&valid_acc);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_WAIT;
            count        <= 8'd0;
            prev_bus     <= '1;
            digitValue   <= '0;
            digitValid   <= '0;
            frameValue   <= '0;
            frameValid   <= 1'b0;
            overrun      <= 1'b0;
            patternError <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            prev_bus   <= cur_bus;
            digitValue <= digit_nx;
            digitValid <= complete ? '0 : valid_acc;
            if (capture && dec[4]) begin
                patternError <= 1'b1;
            end
            // A completing frame wins over ack; ack on that edge only suppresses overrun.
            if (complete) begin
                frameValue <= digit_nx;
                frameValid <= 1'b1;
                if (frameValid && !frameAck) begin
                    overrun <= 1'b1;
                end
            end else if (frameAck) begin
                frameValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: directed scenarios plus randomized bus traffic, checked every
// cycle against a run-length based behavioural model. Honours SEVEN_SEG_READER_SYNC_EN.
module tb_seven_segment_reader;
    localparam int DIGITS = 4;
    localparam int STABLE = 3;
`ifdef SEVEN_SEG_READER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int SW = 7 + DIGITS;
    localparam logic [6:0] LIT_TAB [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                           7'b1111111, 7'b1111011};

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [6:0]          seg_n = '1;
    logic [DIGITS-1:0]   sel_n = '1;
    logic                frame_ack = 1'b0;
    logic [4*DIGITS-1:0] digit_value;
    logic [DIGITS-1:0]   digit_valid;
    logic [4*DIGITS-1:0] frame_value;
    logic                frame_valid;
    logic                overrun;
    logic                pattern_error;

    seven_segment_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clock(clock), .reset(reset),
        .A(seg_n[6]), .B(seg_n[5]), .C(seg_n[4]), .D(seg_n[3]),
        .E(seg_n[2]), .F(seg_n[1]), .G(seg_n[0]),
        .digitSelect(sel_n), .frameAck(frame_ack),
        .digitValue(digit_value), .digitValid(digit_valid),
        .frameValue(frame_value), .frameValid(frame_valid),
        .overrun(overrun), .patternError(pattern_error)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a digit is captured when the same one-hot sample has been seen
    // for exactly STABLE consecutive edges.
    logic [3:0]          m_code [DIGITS];
    logic [DIGITS-1:0]   m_valid;
    logic [4*DIGITS-1:0] m_frame;
    logic                m_fvalid, m_over, m_perr;
    logic [SW-1:0]       m_prev, m_s1, m_s2;
    int                  m_run;

    function automatic logic [4*DIGITS-1:0] pack_codes();
        logic [4*DIGITS-1:0] v;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = m_code[i];
        return v;
    endfunction

    task automatic model_decode(input logic [6:0] lit, output logic [3:0] code, output bit err);
        err  = 1'b0;
        code = 4'hE;
        if (lit == 7'd0) code = 4'hF;
        else begin
            err = 1'b1;
            for (int d = 0; d < 10; d++)
                if (lit == LIT_TAB[d]) begin
                    code = 4'(d);
                    err  = 1'b0;
                end
        end
    endtask

    always @(posedge clock) begin : model
        logic [SW-1:0]     in_v, cur;
        logic [DIGITS-1:0] lit_sel;
        logic [3:0]        code;
        bit                err;
        int                idx;
        in_v = {seg_n, sel_n};
        if (reset) begin
            for (int i = 0; i < DIGITS; i++) m_code[i] = 4'h0;
            m_valid = '0; m_frame = '0; m_fvalid = 1'b0; m_over = 1'b0; m_perr = 1'b0;
            m_prev = '1; m_s1 = '1; m_s2 = '1; m_run = 0;
        end else begin
            cur  = (LAT == 0) ? in_v : m_s2;
            m_s2 = m_s1;
            m_s1 = in_v;
            lit_sel = ~cur[DIGITS-1:0];
            if ($countones(lit_sel) == 1) begin
                if (cur == m_prev && m_run > 0) begin
                    if (m_run < 1000) m_run++;
                end else m_run = 1;
            end else m_run = 0;
            if (m_run == STABLE) begin
                idx = 0;
                for (int i = 0; i < DIGITS; i++) if (lit_sel[i]) idx = i;
                model_decode(~cur[SW-1:DIGITS], code, err);
                m_code[idx] = code;
                m_valid[idx] = 1'b1;
                if (err) m_perr = 1'b1;
            end
            if (m_run == STABLE && m_valid == '1) begin
                if (m_fvalid && !frame_ack) m_over = 1'b1;
                m_frame  = pack_codes();
                m_fvalid = 1'b1;
                m_valid  = '0;
            end else if (frame_ack) m_fvalid = 1'b0;
            m_prev = cur;
        end
    end

    always @(negedge clock) begin
        if (started) begin
            check("digitValue",   32'(digit_value),   32'(pack_codes()));
            check("digitValid",   32'(digit_valid),   32'(m_valid));
            check("frameValue",   32'(frame_value),   32'(m_frame));
            check("frameValid",   32'(frame_valid),   32'(m_fvalid));
            check("overrun",      32'(overrun),       32'(m_over));
            check("patternError", 32'(pattern_error), 32'(m_perr));
        end
    end

    function automatic logic [DIGITS-1:0] sel_of(input int d);
        logic [DIGITS-1:0] one;
        one = DIGITS'(1);
        return ~(one << d);
    endfunction

    task automatic hold(input logic [6:0] lit, input logic [DIGITS-1:0] sel, input int n);
        seg_n = ~lit;
        sel_n = sel;
        repeat (n) @(negedge clock);
    endtask

    task automatic idle(input int n);
        hold(7'd0, '1, n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
    endtask

    task automatic scan(input logic [15:0] val, input int n);
        logic [3:0] dg;
        for (int d = 0; d < n; d++) begin
            dg = val[4*d +: 4];
            hold(LIT_TAB[dg], sel_of(d), STABLE);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]        lit;
        logic [DIGITS-1:0] sel;
        int                k;
        reset = 1'b1;
        @(posedge clock);
        #1 started = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_digitValid", 32'(digit_valid), 32'd0);
        check("rst_frameValid", 32'(frame_valid), 32'd0);
        check("rst_frameValue", 32'(frame_value), 32'd0);

        // single digit capture latency
        hold(LIT_TAB[1], sel_of(0), STABLE - 1 + LAT);
        check("t1_not_yet", 32'(digit_valid), 32'd0);
        hold(LIT_TAB[1], sel_of(0), 1);
        check("t1_valid", 32'(digit_valid), 32'b0001);
        check("t1_code", 32'(digit_value[3:0]), 32'd1);
        idle(2 + LAT);

        // full frame and handshake
        do_reset();
        scan(16'h4321, 3);
        hold(LIT_TAB[4], sel_of(3), STABLE - 1 + LAT);
        check("t2_fv_early", 32'(frame_valid), 32'd0);
        hold(LIT_TAB[4], sel_of(3), 1);
        check("t2_fv", 32'(frame_valid), 32'd1);
        check("t2_frame", 32'(frame_value), 32'h4321);
        check("t2_dvalid", 32'(digit_valid), 32'd0);
        check("t2_dvalue", 32'(digit_value), 32'h4321);
        check("t2_model_frame", 32'(m_frame), 32'h4321);
        idle(2);
        frame_ack = 1'b1;
        idle(1);
        frame_ack = 1'b0;
        check("t2_ack_fv", 32'(frame_valid), 32'd0);
        check("t2_ack_frame", 32'(frame_value), 32'h4321);

        // settle restart on a flipped segment
        do_reset();
        hold(LIT_TAB[5], sel_of(0), 1);
        hold(LIT_TAB[6], sel_of(0), STABLE - 1 + LAT);
        check("t3_flip_early", 32'(digit_valid), 32'd0);
        hold(LIT_TAB[6], sel_of(0), 1);
        check("t3_flip_valid", 32'(digit_valid), 32'b0001);
        check("t3_flip_code", 32'(digit_value[3:0]), 32'd6);

        // two selects low: no capture
        do_reset();
        hold(LIT_TAB[8], 4'b1100, 10);
        check("t3_multi_valid", 32'(digit_valid), 32'd0);
        check("t3_multi_value", 32'(digit_value), 32'd0);

        // blank and undecodable patterns
        do_reset();
        hold(7'b0000000, sel_of(1), STABLE + LAT);
        check("t4_blank_code", 32'(digit_value[7:4]), 32'hF);
        check("t4_blank_perr", 32'(pattern_error), 32'd0);
        hold(7'b1000001, sel_of(2), STABLE + LAT);
        check("t4_bad_code", 32'(digit_value[11:8]), 32'hE);
        check("t4_bad_perr", 32'(pattern_error), 32'd1);
        idle(5);
        check("t4_perr_sticky", 32'(pattern_error), 32'd1);
        do_reset();
        check("t4_perr_reset", 32'(pattern_error), 32'd0);

        // overrun without and with ack on the completing edge
        do_reset();
        scan(16'h4321, 4);
        scan(16'h8765, 4);
        idle(LAT + 1);
        check("t5_overrun", 32'(overrun), 32'd1);
        check("t5_model_over", 32'(m_over), 32'd1);
        check("t5_frame", 32'(frame_value), 32'h8765);
        check("t5_fv", 32'(frame_valid), 32'd1);
        do_reset();
        check("t5_over_reset", 32'(overrun), 32'd0);
        scan(16'h4321, 4);
        scan(16'h8765, 3);
        hold(LIT_TAB[8], sel_of(3), STABLE - 1 + LAT);
        frame_ack = 1'b1;
        hold(LIT_TAB[8], sel_of(3), 1);
        frame_ack = 1'b0;
        check("t5_ack_over", 32'(overrun), 32'd0);
        check("t5_ack_fv", 32'(frame_valid), 32'd1);
        check("t5_ack_frame", 32'(frame_value), 32'h8765);

        // reset mid-frame
        do_reset();
        scan(16'h2468, 2);
        idle(LAT);
        check("t6_partial", 32'(digit_valid), 32'b0011);
        do_reset();
        check("t6_rst_valid", 32'(digit_valid), 32'd0);
        check("t6_rst_value", 32'(digit_value), 32'd0);
        check("t6_rst_fv", 32'(frame_valid), 32'd0);
        scan(16'h2468, 4);
        idle(LAT);
        check("t6_frame", 32'(frame_value), 32'h2468);
        check("t6_fv", 32'(frame_valid), 32'd1);

        // randomized traffic, checked by the per-cycle compare process
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                frame_ack = 1'b0;
                do_reset();
            end else begin
                k = int'($urandom_range(0, 11));
                if (k < 10) lit = LIT_TAB[k];
                else if (k == 10) lit = 7'd0;
                else lit = 7'($urandom);
                k = int'($urandom_range(0, 9));
                if (k < 8) sel = sel_of(int'($urandom_range(0, DIGITS - 1)));
                else if (k == 8) sel = '1;
                else sel = DIGITS'($urandom);
                frame_ack = ($urandom_range(0, 3) == 0);
                hold(lit, sel, int'($urandom_range(1, 5)));
            end
        end
        frame_ack = 1'b0;
        idle(3);
        started = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seven_segment_reader.md
# seven_segment_reader

Receiving end of the seven-segment output path: samples a multiplexed, active-low seven-segment bus (segments A–G plus an active-low digit-select strobe), waits for each strobed digit to settle, and decodes the segment pattern back into a 4-bit digit code. Decoded digits are assembled into a frame that is handed off with a valid/ack handshake. It sits on the processor's output side as a display monitor, so the displayed value can be checked without probing the register file.

## Interface
- `DIGITS`, 4: number of multiplexed digits (1–8).
- `STABLE_CYCLES`, 3: consecutive identical samples required before capture (2–255).
- `clock` input 1: rising-edge clock; the only clock in the block.
- `reset` input 1: synchronous, active-high.
- `A`,`B`,`C`,`D`,`E`,`F`,`G` inputs 1 each: segment lines, active-low (0 = lit).
- `digitSelect` input `DIGITS`: active-low one-hot digit strobe; bit i low selects digit i.
- `frameAck` input 1: consumer accepts `frameValue`.
- `digitValue` output 4*`DIGITS`: live decoded codes; digit i occupies bits [4i+3:4i].
- `digitValid` output `DIGITS`: digit i captured in the current frame.
- `frameValue` output 4*`DIGITS`: last completed frame.
- `frameValid` output 1: `frameValue` holds an unacknowledged frame.
- `overrun` output 1: sticky; a frame completed while the previous one was still unacknowledged.
- `patternError` output 1: sticky; an undecodable pattern was captured.

## Operation
- Decode, with lit-segment set {A..G} = ~{A..G}. 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9. 0000000 (blank)→4'hF, no error. Any other pattern→4'hE and sets `patternError`.
- The sample register holds {segments, digitSelect} from the previous edge.
- **WAIT** state: `digitSelect` is not exactly one low bit. Nothing is captured. Go to SETTLE with count=1 when it becomes one-hot.
- **SETTLE** state:
  - Sample equal to the previous sample: count increments.
  - Sample differs, still one-hot: count returns to 1.
  - Select not one-hot: go to WAIT.
  - Count reaches `STABLE_CYCLES`: capture the decoded code into slot i, set `digitValid[i]`, go to HOLD.
- **HOLD** state: no recapture while the sample is unchanged. A change goes to SETTLE (count=1) or to WAIT, per the rules above.
- Recapturing an already-valid digit before the frame completes overwrites its code.
- **Frame complete:** the capture that makes all `digitValid` bits 1. On that same edge:
  - `frameValue` ← the assembled codes, including the new digit.
  - `frameValid` ← 1.
  - `digitValid` ← 0.
  - `digitValue` retains its contents.
- **Handshake:** `frameValid` and `frameValue` hold until an edge with `frameAck`=1, which clears `frameValid`. `frameAck` while `frameValid`=0 is ignored.
- **New frame completes while `frameValid`=1:**
  - With `frameAck`=0 on that edge: `frameValue` is overwritten, `frameValid` stays 1, and `overrun` ← 1.
  - With `frameAck`=1 on that edge: new value is loaded, `frameValid` stays 1, and `overrun` is not set.
- `overrun` and `patternError` clear only on reset.

## Timing
- Reset values: state=WAIT, count=0, `digitValue`=0, `digitValid`=0, `frameValue`=0, `frameValid`=0, `overrun`=0, `patternError`=0. The sample register resets to all-ones (blank, nothing selected).
- Capture latency: an input stable from before edge k is captured on edge k+`STABLE_CYCLES`−1 and is visible after that edge. For the default, inputs applied before edge 1 are captured at edge 3.
- `frameValid` rises on the same edge as the completing capture. It falls on the first edge with `frameAck`=1.
- `reset` mid-SETTLE or mid-frame discards partial digits and any pending frame.
- Add 2 cycles to all latencies when `SEVEN_SEG_READER_SYNC_EN` is defined.

## Configuration
- `SEVEN_SEG_READER_SYNC_EN` defined: A–G and `digitSelect` each pass through a 2-flop synchroniser before the sample register. Synchroniser flops reset to all-ones. Use this when the display bus comes from another clock domain or off-chip.
- Not defined: inputs feed the sample register directly. The block then requires a source synchronous to `clock`.

## Test plan
- Reset, then strobe digit 0 with lit pattern 0110000 for 3 cycles → `digitValue[3:0]`=1, `digitValid`=0001 after edge 3, no earlier.
- Scan digits 0–3 with "1","2","3","4", each held 3 cycles → `frameValid`=1 on the last capture edge, `frameValue`=16'h4321, `digitValid`=0000. `frameAck` pulse → `frameValid`=0.
- Strobe a digit with a pattern that flips one segment on cycle 2, then holds → count restarts and capture occurs 3 edges after the flip. A strobe with two `digitSelect` bits low for 10 cycles → no capture.
- Lit pattern 0000000 → code 4'hF, `patternError`=0. Lit pattern 1000001 → code 4'hE, `patternError`=1, which stays 1 until reset.
- Complete two frames without `frameAck` → `overrun`=1 and `frameValue` = second frame. Repeat with `frameAck`=1 on the completing edge → `overrun`=0, `frameValid`=1.
- Assert `reset` with 2 of 4 digits captured → all outputs return to reset values, and the next full scan produces a correct frame.
